// File: rtl/dca_neugemm_seq_pkg.sv
// Shared constants for the NEUGEMM tile sequencer: LSU opcodes, default widths, FSM states.
package dca_neugemm_seq_pkg;

  localparam int unsigned DEF_BW_ADDR = 32;
  localparam int unsigned DEF_BW_KCNT = 16;
  localparam int unsigned BW_OPC      = 2;

  localparam logic [BW_OPC-1:0] OPC_LOAD  = 2'b01;
  localparam logic [BW_OPC-1:0] OPC_STORE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_AB,
    ST_WAIT_AB,
    ST_STEP,
    ST_ISSUE_C,
    ST_WAIT_C,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/dca_neugemm_seq_issue_port.sv
// One LSU instruction port: holds valid until handshake, keeps the instruction stable,
// and records a sticky execute_finish while armed.
module dca_neugemm_seq_issue_port #(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] inst_i,
  input  logic         arm_i,
  input  logic         clr_fin_i,
  input  logic         wready_i,
  input  logic         finish_i,
  output logic         wvalid_o,
  output logic [W-1:0] wdata_o,
  output logic         fin_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         fin_q, fin_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    fin_d   = fin_q;
    if (valid_q && wready_i) begin
      valid_d = 1'b0;
    end
    if (start_i) begin
      valid_d = 1'b1;
      data_d  = inst_i;
    end
    // finish in the handshake cycle is armed too, so it is never lost
    if (clr_fin_i) begin
      fin_d = 1'b0;
    end else if (arm_i && finish_i) begin
      fin_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      fin_q   <= fin_d;
    end
  end

  assign wvalid_o = valid_q;
  assign wdata_o  = data_q;
  assign fin_o    = fin_q;

endmodule

// File: rtl/dca_neugemm_tile_sequencer.sv
// Sequences one GEMM tile: per k-step load A and B, wait for both, hand a step to the MAC,
// then store C and pulse done.
module dca_neugemm_tile_sequencer
  import dca_neugemm_seq_pkg::*;
#(
  parameter int unsigned BW_ADDR     = DEF_BW_ADDR,
  parameter int unsigned BW_KCNT     = DEF_BW_KCNT,
  parameter int unsigned BW_LSU_INST = BW_OPC + BW_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [BW_ADDR-1:0]     cmd_a_addr,
  input  logic [BW_ADDR-1:0]     cmd_b_addr,
  input  logic [BW_ADDR-1:0]     cmd_c_addr,
  input  logic [BW_ADDR-1:0]     cmd_a_stride,
  input  logic [BW_ADDR-1:0]     cmd_b_stride,
  input  logic [BW_KCNT-1:0]     cmd_num_k,
  output logic                   busy,
  output logic                   done,
  output logic                   ma_sinst_wvalid,
  output logic [BW_LSU_INST-1:0] ma_sinst_wdata,
  input  logic                   ma_sinst_wready,
  input  logic                   ma_sinst_execute_finish,
  output logic                   mb_sinst_wvalid,
  output logic [BW_LSU_INST-1:0] mb_sinst_wdata,
  input  logic                   mb_sinst_wready,
  input  logic                   mb_sinst_execute_finish,
  output logic                   mc_sinst_wvalid,
  output logic [BW_LSU_INST-1:0] mc_sinst_wdata,
  input  logic                   mc_sinst_wready,
  input  logic                   mc_sinst_execute_finish,
  output logic                   mac_clear,
  output logic                   mac_step_valid,
  input  logic                   mac_step_ready
);

  seq_state_e state_q, state_d;

  logic [BW_ADDR-1:0] a_addr_q, a_addr_d;
  logic [BW_ADDR-1:0] b_addr_q, b_addr_d;
  logic [BW_ADDR-1:0] c_addr_q, c_addr_d;
  logic [BW_ADDR-1:0] a_stride_q, a_stride_d;
  logic [BW_ADDR-1:0] b_stride_q, b_stride_d;
  logic [BW_KCNT-1:0] num_k_q, num_k_d;
  logic [BW_KCNT-1:0] k_cnt_q, k_cnt_d;

  logic cmd_ready_q, busy_q, done_q, mac_clear_q, mac_step_valid_q;

  logic accept_c;
  logic start_a_c, start_b_c, start_c_c;
  logic clr_ab_c, clr_c_c;
  logic arm_ab_c, arm_c_c;
  logic fin_a, fin_b, fin_c;

  logic [BW_LSU_INST-1:0] inst_a_c, inst_b_c, inst_c_c;

  // Next-state, counter and address update
  always_comb begin
    state_d    = state_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    c_addr_d   = c_addr_q;
    a_stride_d = a_stride_q;
    b_stride_d = b_stride_q;
    num_k_d    = num_k_q;
    k_cnt_d    = k_cnt_q;
    accept_c   = 1'b0;
    start_a_c  = 1'b0;
    start_b_c  = 1'b0;
    start_c_c  = 1'b0;
    clr_ab_c   = 1'b0;
    clr_c_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept_c   = 1'b1;
          a_addr_d   = cmd_a_addr;
          b_addr_d   = cmd_b_addr;
          c_addr_d   = cmd_c_addr;
          a_stride_d = cmd_a_stride;
          b_stride_d = cmd_b_stride;
          num_k_d    = cmd_num_k;
          k_cnt_d    = '0;
          if (cmd_num_k == '0) begin
            start_c_c = 1'b1;
            state_d   = ST_ISSUE_C;
          end else begin
            start_a_c = 1'b1;
            start_b_c = 1'b1;
            state_d   = ST_ISSUE_AB;
          end
        end
      end
      ST_ISSUE_AB: begin
        if ((!ma_sinst_wvalid || ma_sinst_wready) &&
            (!mb_sinst_wvalid || mb_sinst_wready)) begin
          state_d = ST_WAIT_AB;
        end
      end
      ST_WAIT_AB: begin
        if (fin_a && fin_b) begin
          clr_ab_c = 1'b1;
          state_d  = ST_STEP;
        end
      end
      ST_STEP: begin
        if (mac_step_valid_q && mac_step_ready) begin
          if (k_cnt_q == num_k_q - BW_KCNT'(1)) begin
            start_c_c = 1'b1;
            state_d   = ST_ISSUE_C;
          end else begin
            a_addr_d  = a_addr_q + a_stride_q;
            b_addr_d  = b_addr_q + b_stride_q;
            k_cnt_d   = k_cnt_q + BW_KCNT'(1);
            start_a_c = 1'b1;
            start_b_c = 1'b1;
            state_d   = ST_ISSUE_AB;
          end
        end
      end
      ST_ISSUE_C: begin
        if (mc_sinst_wvalid && mc_sinst_wready) begin
          state_d = ST_WAIT_C;
        end
      end
      ST_WAIT_C: begin
        if (fin_c) begin
          clr_c_c = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign arm_ab_c = (state_q == ST_ISSUE_AB) || (state_q == ST_WAIT_AB);
  assign arm_c_c  = (state_q == ST_ISSUE_C)  || (state_q == ST_WAIT_C);

  // Instructions take the post-update address so the first issue follows accept directly
  assign inst_a_c = {OPC_LOAD,  a_addr_d};
  assign inst_b_c = {OPC_LOAD,  b_addr_d};
  assign inst_c_c = {OPC_STORE, c_addr_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      a_addr_q         <= '0;
      b_addr_q         <= '0;
      c_addr_q         <= '0;
      a_stride_q       <= '0;
      b_stride_q       <= '0;
      num_k_q          <= '0;
      k_cnt_q          <= '0;
      cmd_ready_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mac_clear_q      <= 1'b0;
      mac_step_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      a_addr_q         <= a_addr_d;
      b_addr_q         <= b_addr_d;
      c_addr_q         <= c_addr_d;
      a_stride_q       <= a_stride_d;
      b_stride_q       <= b_stride_d;
      num_k_q          <= num_k_d;
      k_cnt_q          <= k_cnt_d;
      cmd_ready_q      <= (state_d == ST_IDLE);
      busy_q           <= (state_d != ST_IDLE);
      done_q           <= (state_d == ST_DONE);
      mac_clear_q      <= accept_c;
      mac_step_valid_q <= (state_d == ST_STEP);
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mac_clear      = mac_clear_q;
  assign mac_step_valid = mac_step_valid_q;

  dca_neugemm_seq_issue_port #(.W(BW_LSU_INST)) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_a_c),
    .inst_i    (inst_a_c),
    .arm_i     (arm_ab_c),
    .clr_fin_i (clr_ab_c),
    .wready_i  (ma_sinst_wready),
    .finish_i  (ma_sinst_execute_finish),
    .wvalid_o  (ma_sinst_wvalid),
    .wdata_o   (ma_sinst_wdata),
    .fin_o     (fin_a)
  );

  dca_neugemm_seq_issue_port #(.W(BW_LSU_INST)) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_b_c),
    .inst_i    (inst_b_c),
    .arm_i     (arm_ab_c),
    .clr_fin_i (clr_ab_c),
    .wready_i  (mb_sinst_wready),
    .finish_i  (mb_sinst_execute_finish),
    .wvalid_o  (mb_sinst_wvalid),
    .wdata_o   (mb_sinst_wdata),
    .fin_o     (fin_b)
  );

  dca_neugemm_seq_issue_port #(.W(BW_LSU_INST)) u_port_c (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_c_c),
    .inst_i    (inst_c_c),
    .arm_i     (arm_c_c),
    .clr_fin_i (clr_c_c),
    .wready_i  (mc_sinst_wready),
    .finish_i  (mc_sinst_execute_finish),
    .wvalid_o  (mc_sinst_wvalid),
    .wdata_o   (mc_sinst_wdata),
    .fin_o     (fin_c)
  );

endmodule

// File: tb/tb_dca_neugemm_tile_sequencer.sv
// Directed bench for the tile sequencer: table of tile jobs with hand-computed LSU traffic,
// plus hand sequences for stray finishes and mid-job reset.
module tb_dca_neugemm_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_a_stride, cmd_b_stride;
  logic [15:0] cmd_num_k;
  logic        busy, done;
  logic        va, vb, vc;
  logic [33:0] wd_a, wd_b, wd_c;
  logic        ra, rb, rc;
  logic        fa, fb, fc;
  logic        mac_clear, mac_step_valid;
  logic        mac_step_ready;

  always #5 clk = ~clk;

  dca_neugemm_tile_sequencer dut (
    .clk                     (clk),
    .rst                     (rst),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_a_addr              (cmd_a_addr),
    .cmd_b_addr              (cmd_b_addr),
    .cmd_c_addr              (cmd_c_addr),
    .cmd_a_stride            (cmd_a_stride),
    .cmd_b_stride            (cmd_b_stride),
    .cmd_num_k               (cmd_num_k),
    .busy                    (busy),
    .done                    (done),
    .ma_sinst_wvalid         (va),
    .ma_sinst_wdata          (wd_a),
    .ma_sinst_wready         (ra),
    .ma_sinst_execute_finish (fa),
    .mb_sinst_wvalid         (vb),
    .mb_sinst_wdata          (wd_b),
    .mb_sinst_wready         (rb),
    .mb_sinst_execute_finish (fb),
    .mc_sinst_wvalid         (vc),
    .mc_sinst_wdata          (wd_c),
    .mc_sinst_wready         (rc),
    .mc_sinst_execute_finish (fc),
    .mac_clear               (mac_clear),
    .mac_step_valid          (mac_step_valid),
    .mac_step_ready          (mac_step_ready)
  );

  typedef struct {
    logic [15:0]      num_k;
    logic [31:0]      a, as_, b, bs, c;
    int               stall_a;
    int               fin_lat;
    logic [2:0][31:0] exp_a;
    logic [2:0][31:0] exp_b;
  } vec_t;

  vec_t vecs[5];

  int n_checks = 0;
  int n_fail   = 0;

  // LSU responder / monitor state
  logic [33:0] qa[$], qb[$], qc[$];
  int stall_left[3];
  int fin_cnt[3];
  int fin_set[3];
  logic prev_v[3], prev_r[3];
  logic [33:0] prev_d[3];
  int fin_lat = 2;
  int stab_err = 0, order_err = 0;
  int steps = 0, clr_cnt = 0, done_cnt = 0;
  logic stray = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic lsu_tick(input int i, input logic v, input logic [33:0] d,
                          output logic r, output logic f);
    f = 1'b0;
    r = 1'b0;
    if (fin_cnt[i] > 0) begin
      fin_cnt[i]--;
      if (fin_cnt[i] == 0) begin
        f = 1'b1;
        fin_set[i]++;
      end
    end
    if (v && prev_v[i] && !prev_r[i] && d != prev_d[i]) stab_err++;
    if (v) begin
      if (stall_left[i] > 0) begin
        stall_left[i]--;
      end else begin
        r = 1'b1;
        case (i)
          0: qa.push_back(d);
          1: qb.push_back(d);
          default: qc.push_back(d);
        endcase
        if (fin_lat == 0) begin
          f = 1'b1;
          fin_set[i]++;
        end else begin
          fin_cnt[i] = fin_lat;
        end
      end
    end
    prev_v[i] = v;
    prev_r[i] = r;
    prev_d[i] = d;
    f = f | stray;
  endtask

  // Responders act on the falling edge, so DUT outputs are settled and inputs are ready by the rising edge
  initial begin
    ra = 0; rb = 0; rc = 0; fa = 0; fb = 0; fc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ra = 0; rb = 0; rc = 0; fa = 0; fb = 0; fc = 0;
        for (int i = 0; i < 3; i++) begin
          fin_cnt[i] = 0; stall_left[i] = 0; prev_v[i] = 0; prev_r[i] = 0; prev_d[i] = '0;
        end
      end else begin
        lsu_tick(0, va, wd_a, ra, fa);
        lsu_tick(1, vb, wd_b, rb, fb);
        lsu_tick(2, vc, wd_c, rc, fc);
        if (mac_step_valid && mac_step_ready) begin
          if (fin_set[0] != steps + 1 || fin_set[1] != steps + 1) order_err++;
          steps++;
        end
        if (mac_clear) clr_cnt++;
        if (done) begin
          if (fin_set[2] != 1) order_err++;
          done_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(input vec_t v, input string tag);
    int n;
    qa.delete(); qb.delete(); qc.delete();
    steps = 0; clr_cnt = 0; done_cnt = 0; stab_err = 0; order_err = 0;
    for (int i = 0; i < 3; i++) begin
      fin_set[i] = 0; fin_cnt[i] = 0; stall_left[i] = 0;
    end
    stall_left[0] = v.stall_a;
    fin_lat = v.fin_lat;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_a_addr = v.a; cmd_a_stride = v.as_;
    cmd_b_addr = v.b; cmd_b_stride = v.bs;
    cmd_c_addr = v.c; cmd_num_k = v.num_k;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    if (v.num_k != 16'd0) begin
      check({tag, "_lat_ab"}, 64'({va, vb, vc}), 64'b110);
      check({tag, "_first_a"}, 64'(wd_a), 64'({2'b01, v.a}));
    end else begin
      check({tag, "_lat_c"}, 64'({va, vb, vc}), 64'b001);
    end
    check({tag, "_clear_busy"}, 64'({mac_clear, busy, cmd_ready}), 64'b110);
  endtask

  task automatic finish_job(input vec_t v, input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    tick(); tick(); tick();
    check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    check({tag, "_idle"}, 64'({busy, cmd_ready}), 64'b01);
    check({tag, "_n_a"}, 64'(qa.size()), 64'(v.num_k));
    check({tag, "_n_b"}, 64'(qb.size()), 64'(v.num_k));
    check({tag, "_n_c"}, 64'(qc.size()), 64'd1);
    check({tag, "_c_inst"}, (qc.size() > 0) ? 64'(qc[0]) : 64'hx, 64'({2'b10, v.c}));
    for (int k = 0; k < int'(v.num_k) && k < 3; k++) begin
      check($sformatf("%s_a%0d", tag, k), (k < qa.size()) ? 64'(qa[k]) : 64'hx,
            64'({2'b01, v.exp_a[k]}));
      check($sformatf("%s_b%0d", tag, k), (k < qb.size()) ? 64'(qb[k]) : 64'hx,
            64'({2'b01, v.exp_b[k]}));
    end
    check({tag, "_steps"}, 64'(steps), 64'(v.num_k));
    check({tag, "_clears"}, 64'(clr_cnt), 64'd1);
    check({tag, "_stable"}, 64'(stab_err), 64'd0);
    check({tag, "_order"}, 64'(order_err), 64'd0);
  endtask

  initial begin
    vec_t sv;
    int n;

    vecs[0] = '{num_k: 16'd3, a: 32'h1000, as_: 32'h40, b: 32'h2000, bs: 32'h80, c: 32'h3000,
                stall_a: 0, fin_lat: 2,
                exp_a: {32'h1080, 32'h1040, 32'h1000}, exp_b: {32'h2100, 32'h2080, 32'h2000}};
    vecs[1] = '{num_k: 16'd0, a: 32'h1111, as_: 32'h4, b: 32'h2222, bs: 32'h4, c: 32'h4000,
                stall_a: 0, fin_lat: 2, exp_a: '0, exp_b: '0};
    vecs[2] = '{num_k: 16'd1, a: 32'h5000, as_: 32'h40, b: 32'h6000, bs: 32'h40, c: 32'h7000,
                stall_a: 5, fin_lat: 2, exp_a: {32'h0, 32'h0, 32'h5000}, exp_b: {32'h0, 32'h0, 32'h6000}};
    vecs[3] = '{num_k: 16'd2, a: 32'h100, as_: 32'h10, b: 32'h200, bs: 32'h20, c: 32'h300,
                stall_a: 0, fin_lat: 0, exp_a: {32'h0, 32'h110, 32'h100}, exp_b: {32'h0, 32'h220, 32'h200}};
    vecs[4] = '{num_k: 16'd2, a: 32'hFFFF_FFC0, as_: 32'h40, b: 32'h8000, bs: 32'h8, c: 32'h9000,
                stall_a: 0, fin_lat: 2, exp_a: {32'h0, 32'h0000_0000, 32'hFFFF_FFC0},
                exp_b: {32'h0, 32'h8008, 32'h8000}};

    rst = 1'b1; cmd_valid = 1'b0; mac_step_ready = 1'b1;
    cmd_a_addr = '0; cmd_b_addr = '0; cmd_c_addr = '0;
    cmd_a_stride = '0; cmd_b_stride = '0; cmd_num_k = '0;
    tick(); tick(); tick();
    check("reset_ctrl", 64'({cmd_ready, busy, done, va, vb, vc, mac_clear, mac_step_valid}), 64'd0);
    check("reset_data", 64'(wd_a | wd_b | wd_c), 64'd0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    for (int t = 0; t < 5; t++) begin
      start_job(vecs[t], $sformatf("job%0d", t));
      finish_job(vecs[t], $sformatf("job%0d", t));
    end

    // Stray finishes while idle must not pre-satisfy the next job
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick(); tick();
    check("stray_idle", 64'({busy, done, cmd_ready}), 64'b001);
    sv = vecs[2];
    sv.stall_a = 0;
    sv.fin_lat = 3;
    start_job(sv, "stray");
    finish_job(sv, "stray");

    // Reset during WAIT_AB of the second k-step
    start_job(vecs[0], "mid");
    n = 0;
    while (!(qa.size() == 2 && !va && !vb && steps == 1) && n < 200) begin
      tick();
      n++;
    end
    check("mid_reach_wait_ab", 64'(n < 200), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", 64'({cmd_ready, busy, done, va, vb, vc, mac_clear, mac_step_valid}), 64'd0);
    check("mid_rst_data", 64'(wd_a | wd_b | wd_c), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("mid_ready_after", 64'({cmd_ready, busy}), 64'b10);
    check("mid_no_done", 64'(done_cnt), 64'd0);
    start_job(vecs[0], "rerun");
    finish_job(vecs[0], "rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
